// File: rtl/mem_store_buf_pkg.sv
// Shared memory-stage definitions: store/load op encodings, byte-enable width and the
// word-address slice point used by both the store buffer and the load-data extender.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_SW  = 2'd0,
      ST_SB  = 2'd1,
      ST_SH  = 2'd2,
      ST_RSV = 2'd3
   } st_op_e;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } ld_op_e;

   localparam int BE_W     = 4;
   localparam int WORD_LSB = 2;

   // Word address of a 32-bit byte address.
   function automatic logic [31-WORD_LSB:0] word_of(input logic [31:0] addr);
      return addr[31:WORD_LSB];
   endfunction

   function automatic logic is_store(input st_op_e op);
      return op != ST_RSV;
   endfunction

endpackage

// File: rtl/mem_store_buf_if.sv
// Store-buffer bus: M-stage store/load-probe side plus the data-memory write port.
interface mem_store_buf_if #(parameter int AW = 32);
   logic          st_valid;
   logic [1:0]    st_op;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;
   logic          st_stall;
   logic          st_ades;
   logic [AW-1:0] ld_addr;
   logic          ld_hit;
   logic          dm_req;
   logic [AW-1:0] dm_addr;
   logic [3:0]    dm_be;
   logic [31:0]   dm_wdata;
   logic          dm_ready;

   modport slave (
      input  st_valid, st_op, st_addr, st_data, ld_addr, dm_ready,
      output st_stall, st_ades, ld_hit, dm_req, dm_addr, dm_be, dm_wdata
   );

   modport master (
      output st_valid, st_op, st_addr, st_data, ld_addr, dm_ready,
      input  st_stall, st_ades, ld_hit, dm_req, dm_addr, dm_be, dm_wdata
   );
endinterface

// File: rtl/mem_store_buf_lane_gen.sv
// Store lane generator: byte enables, lane-replicated write data and misalignment
// for sw/sh/sb given the low address bits.
module store_lane_gen
   import mem_pkg::*;
(
   input  st_op_e          i_op,
   input  logic [1:0]      i_lane,
   input  logic [31:0]     i_data,
   output logic [BE_W-1:0] o_be,
   output logic [31:0]     o_wdata,
   output logic            o_misaligned
);

   always_comb begin
      o_be         = '0;
      o_wdata      = '0;
      o_misaligned = 1'b0;
      case (i_op)
         ST_SW: begin
            o_be         = 4'b1111;
            o_wdata      = i_data;
            o_misaligned = (i_lane != 2'b00);
         end
         ST_SH: begin
            o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_data[15:0]}};
            o_misaligned = i_lane[0];
         end
         ST_SB: begin
            o_be    = BE_W'(1) << i_lane;
            o_wdata = {4{i_data[7:0]}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_store_buf.sv
// M-stage store buffer: converts stores to word writes with byte enables and queues them
// in a small FIFO so a stalling data memory only stalls M when the queue is full.
module mem_store_buf
   import mem_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32
)(
   input  logic          clk,
   input  logic          reset_n,
   mem_store_buf_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int WW = AW - WORD_LSB;

   logic [WW-1:0]   r_addr [DEPTH];
   logic [BE_W-1:0] r_be   [DEPTH];
   logic [31:0]     r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   st_op_e          w_op;
   logic [BE_W-1:0] w_be;
   logic [31:0]     w_wdata;
   logic            w_mis;
   logic            w_is_store;
   logic            w_ades;
   logic            w_full;
   logic            w_req;
   logic            w_push;
   logic            w_pop;
   logic            w_hit;
   logic            w_unused;

   assign w_op = st_op_e'(bus.st_op);

   store_lane_gen u_lane_gen (
      .i_op         (w_op),
      .i_lane       (bus.st_addr[1:0]),
      .i_data       (bus.st_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_mis)
   );

   assign w_is_store = bus.st_valid & is_store(w_op);
   assign w_ades     = bus.st_valid & w_mis;
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_req      = (r_count != '0);
   // A pop in the same cycle does not free a slot for this push; full is from the registered count.
   assign w_push     = w_is_store & ~w_ades & ~w_full;
   assign w_pop      = w_req & bus.dm_ready;

   assign bus.st_ades  = w_ades;
   assign bus.st_stall = w_full & w_is_store;
   assign bus.dm_req   = w_req;
   assign bus.dm_addr  = w_req ? {r_addr[r_head], {WORD_LSB{1'b0}}} : '0;
   assign bus.dm_be    = w_req ? r_be[r_head] : '0;
   assign bus.dm_wdata = w_req ? r_data[r_head] : '0;

   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_addr[i] == bus.ld_addr[AW-1:WORD_LSB])) w_hit = 1'b1;
      end
   end
   assign bus.ld_hit = w_hit;
   assign w_unused   = ^bus.ld_addr[WORD_LSB-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_pop) begin
            r_head         <= r_head + PW'(1);
            r_vld[r_head]  <= 1'b0;
         end
         if (w_push) begin
            r_tail         <= r_tail + PW'(1);
            r_vld[r_tail]  <= 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   // Payload is qualified by r_vld/count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= bus.st_addr[AW-1:WORD_LSB];
         r_be[r_tail]   <= w_be;
         r_data[r_tail] <= w_wdata;
      end
   end

endmodule

// File: tb/tb_mem_store_buf.sv
// Directed bench for mem_store_buf with a queue-based reference model checked every cycle.
module tb_mem_store_buf;

   localparam int DEPTH = 2;

   logic clk;
   logic reset_n;
   int   n_total;
   int   n_bad;
   bit   running;

   mem_store_buf_if #(.AW(32)) bus ();

   mem_store_buf #(.DEPTH(DEPTH), .AW(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } ent_t;

   ent_t q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_be(input logic [1:0] op, input logic [31:0] a);
      case (op)
         2'd0:    return 4'hF;
         2'd1:    return 4'(1 << (a % 4));
         2'd2:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] op, input logic [31:0] d);
      case (op)
         2'd0:    return d;
         2'd1:    return (d % 256) * 32'h01010101;
         2'd2:    return (d % 65536) * 32'h00010001;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_ades();
      if (!bus.st_valid) return 1'b0;
      if (bus.st_op == 2'd0) return (bus.st_addr % 4) != 0;
      if (bus.st_op == 2'd2) return (bus.st_addr % 2) != 0;
      return 1'b0;
   endfunction

   function automatic bit m_hit();
      foreach (q[i]) if ((q[i].addr >> 2) == (bus.ld_addr >> 2)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
      end else begin : upd
         bit   push;
         bit   pop;
         ent_t e;
         push   = bus.st_valid && bus.st_op != 2'd3 && !m_ades() && q.size() < DEPTH;
         pop    = q.size() != 0 && bus.dm_ready;
         e.addr = bus.st_addr & ~32'h3;
         e.be   = m_be(bus.st_op, bus.st_addr);
         e.wd   = m_wd(bus.st_op, bus.st_data);
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (running) begin
         chk("m_ades",  32'(bus.st_ades),  32'(m_ades()));
         chk("m_stall", 32'(bus.st_stall),
             32'(q.size() == DEPTH && bus.st_valid && bus.st_op != 2'd3));
         chk("m_hit",   32'(bus.ld_hit),   32'(m_hit()));
         chk("m_req",   32'(bus.dm_req),   32'(q.size() != 0));
         chk("m_addr",  bus.dm_addr,       q.size() != 0 ? q[0].addr : 32'h0);
         chk("m_be",    32'(bus.dm_be),    q.size() != 0 ? 32'(q[0].be) : 32'h0);
         chk("m_wdata", bus.dm_wdata,      q.size() != 0 ? q[0].wd : 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      bus.st_valid = 1'b1;
      bus.st_op    = op;
      bus.st_addr  = a;
      bus.st_data  = d;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      running = 1'b1;
      bus.st_valid = 1'b0;
      bus.st_op    = 2'd0;
      bus.st_addr  = '0;
      bus.st_data  = '0;
      bus.ld_addr  = '0;
      bus.dm_ready = 1'b0;
      reset_n      = 1'b0;
      repeat (2) tick();
      #2;
      chk("rst_req",   32'(bus.dm_req),   0);
      chk("rst_stall", 32'(bus.st_stall), 0);
      chk("rst_hit",   32'(bus.ld_hit),   0);
      chk("rst_addr",  bus.dm_addr,       0);
      reset_n = 1'b1;
      tick();

      // sb to the top lane
      store(2'd1, 32'h1003, 32'h000000A5);
      #2;
      chk("sb_ades", 32'(bus.st_ades), 0);
      chk("sb_stall", 32'(bus.st_stall), 0);
      chk("sb_req_before", 32'(bus.dm_req), 0);
      tick();
      bus.st_valid = 1'b0;
      #2;
      chk("sb_req",   32'(bus.dm_req), 1);
      chk("sb_addr",  bus.dm_addr,     32'h1000);
      chk("sb_be",    32'(bus.dm_be),  32'b1000);
      chk("sb_wdata", bus.dm_wdata,    32'hA5A5A5A5);
      bus.dm_ready = 1'b1;
      tick();
      bus.dm_ready = 1'b0;
      #2;
      chk("sb_drained", 32'(bus.dm_req), 0);

      // sh upper half, then misaligned sh
      store(2'd2, 32'h2002, 32'h1234BEEF);
      tick();
      bus.st_valid = 1'b0;
      #2;
      chk("sh_addr",  bus.dm_addr,    32'h2000);
      chk("sh_be",    32'(bus.dm_be), 32'b1100);
      chk("sh_wdata", bus.dm_wdata,   32'hBEEFBEEF);
      bus.dm_ready = 1'b1;
      tick();
      bus.dm_ready = 1'b0;
      store(2'd2, 32'h2001, 32'h1234BEEF);
      #2;
      chk("sh_ades", 32'(bus.st_ades), 1);
      tick();
      bus.st_valid = 1'b0;
      #2;
      chk("ades_no_push", 32'(bus.dm_req), 0);

      // fill with memory stalled, then pop on a full cycle with a pending push
      store(2'd0, 32'h10, 32'h11111111);
      tick();
      store(2'd0, 32'h14, 32'h22222222);
      tick();
      store(2'd0, 32'h18, 32'h33333333);
      #2;
      chk("full_stall", 32'(bus.st_stall), 1);
      tick();
      #2;
      chk("full_hold_stall", 32'(bus.st_stall), 1);
      chk("full_head", bus.dm_addr, 32'h10);
      bus.dm_ready = 1'b1;
      #1;
      chk("full_pop_stall", 32'(bus.st_stall), 1);
      tick();
      #2;
      chk("after_pop_stall", 32'(bus.st_stall), 0);
      chk("order_2", bus.dm_addr, 32'h14);
      tick();
      bus.st_valid = 1'b0;
      #2;
      chk("order_3", bus.dm_addr, 32'h18);
      chk("order_3_data", bus.dm_wdata, 32'h33333333);
      tick();
      bus.dm_ready = 1'b0;
      #2;
      chk("drain_empty", 32'(bus.dm_req), 0);

      // load hit against queued store
      store(2'd0, 32'h40, 32'h0000CAFE);
      bus.ld_addr = 32'h42;
      #2;
      chk("hit_same_cycle", 32'(bus.ld_hit), 0);
      tick();
      bus.st_valid = 1'b0;
      #2;
      chk("hit_queued", 32'(bus.ld_hit), 1);
      bus.ld_addr = 32'h44;
      #1;
      chk("hit_other_word", 32'(bus.ld_hit), 0);
      bus.ld_addr  = 32'h42;
      bus.dm_ready = 1'b1;
      tick();
      bus.dm_ready = 1'b0;
      #2;
      chk("hit_after_pop", 32'(bus.ld_hit), 0);

      // full: reserved op never stalls, ades independent of fullness
      store(2'd0, 32'h80, 32'hAAAA0000);
      tick();
      store(2'd0, 32'h84, 32'hBBBB0000);
      tick();
      store(2'd3, 32'h88, 32'h0);
      #1;
      chk("rsv_no_stall", 32'(bus.st_stall), 0);
      store(2'd0, 32'h8A, 32'h0);
      #1;
      chk("full_ades", 32'(bus.st_ades), 1);
      chk("full_ades_stall", 32'(bus.st_stall), 1);
      store(2'd2, 32'h8C, 32'h0);
      #1;
      chk("full_sh_ades", 32'(bus.st_ades), 0);
      tick();
      bus.st_valid = 1'b0;
      bus.ld_addr  = 32'h84;
      #1;
      chk("hit_second", 32'(bus.ld_hit), 1);

      // async reset with two entries queued
      reset_n = 1'b0;
      #1;
      chk("areset_req",   32'(bus.dm_req), 0);
      chk("areset_hit",   32'(bus.ld_hit), 0);
      chk("areset_addr",  bus.dm_addr,     0);
      chk("areset_be",    32'(bus.dm_be),  0);
      chk("areset_wdata", bus.dm_wdata,    0);
      tick();
      reset_n = 1'b1;
      store(2'd0, 32'h100, 32'hDEADBEEF);
      tick();
      bus.st_valid = 1'b0;
      #2;
      chk("post_rst_req",  32'(bus.dm_req), 1);
      chk("post_rst_addr", bus.dm_addr,     32'h100);
      chk("post_rst_data", bus.dm_wdata,    32'hDEADBEEF);
      bus.dm_ready = 1'b1;
      tick();
      bus.dm_ready = 1'b0;
      #2;
      chk("post_rst_empty", 32'(bus.dm_req), 0);

      // every sb lane and sh half, streaming with memory ready
      bus.dm_ready = 1'b1;
      for (int a = 0; a < 4; a++) begin
         store(2'd1, 32'h300 + 32'(a), 32'h1234_5A00 + 32'(a));
         tick();
      end
      for (int a = 0; a < 4; a += 2) begin
         store(2'd2, 32'h400 + 32'(a), 32'h9876_0000 + 32'(a));
         tick();
      end
      bus.st_valid = 1'b0;
      repeat (3) tick();

      running = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
